wgt_buffer_loader: RTL



---
 rtl/wgt_buf_pkg.sv | 25 ++
 rtl/wgt_row_packer.sv | 71 +++++++
 rtl/wgt_buffer_loader.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/wgt_buf_pkg.sv
// ============================================================================
// Module      : wgt_buf_pkg
// Description : Shared types and helpers for the weight-buffer write path.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package wgt_buf_pkg;

    localparam int NUM_BANKS = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BANK = 2'd1,
        FILL      = 2'd2,
        COMMIT    = 2'd3
    } ldr_state_e;

    function automatic int calc_bpr(input int tn, input int beat_bytes);
        return tn / beat_bytes;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wgt_row_packer.sv
// ============================================================================
// Module      : wgt_row_packer
// Description : Packs input beats into one buffer row; zero-fills on flush.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module wgt_row_packer
    import wgt_buf_pkg::*;
#(
    parameter int TN         = 128,
    parameter int BEAT_BYTES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    beat_valid,
    input  logic [BEAT_BYTES*8-1:0] beat_data,
    input  logic                    flush,
    output logic                    last_beat,
    output logic                    row_valid,
    output logic [TN*8-1:0]         row_data
);

    localparam int BPR    = calc_bpr(TN, BEAT_BYTES);
    localparam int CNT_W  = (BPR > 1) ? $clog2(BPR) : 1;
    localparam int BEAT_W = BEAT_BYTES * 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TN*8-1:0]  row_q, row_d;
    logic [TN*8-1:0]  row_merged;

    assign last_beat = (cnt_q == CNT_W'(BPR - 1));
    assign row_data  = row_merged;

    // The assembly register is cleared after every emitted row, so any bytes
    // above the current beat are already zero when a flush arrives.
    always_comb begin
        row_merged = row_q;
        row_merged[int'(cnt_q)*BEAT_W +: BEAT_W] = beat_data;
        cnt_d     = cnt_q;
        row_d     = row_q;
        row_valid = 1'b0;
        if (clear) begin
            cnt_d = '0;
            row_d = '0;
        end else if (beat_valid) begin
            if (last_beat || flush) begin
                row_valid = 1'b1;
                cnt_d     = '0;
                row_d     = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                row_d = row_merged;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            row_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            row_q <= row_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wgt_buffer_loader.sv
// ============================================================================
// Module      : wgt_buffer_loader
// Description : DMA-to-weight-SRAM write engine with ping/pong bank handoff.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module wgt_buffer_loader
    import wgt_buf_pkg::*;
#(
    parameter int TN         = 128,
    parameter int ADDR_WIDTH = 7,
    parameter int BEAT_BYTES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH:0]     tile_rows,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [BEAT_BYTES*8-1:0] s_data,
    input  logic                    s_last,
    output logic                    we,
    output logic [ADDR_WIDTH-1:0]   waddr,
    output logic [TN*8-1:0]         wdata,
    output logic                    bank_sel_wr,
    output logic [NUM_BANKS-1:0]    bank_full,
    input  logic                    rel_valid,
    input  logic                    rel_bank,
    output logic                    busy,
    output logic                    tile_done,
    output logic                    err_len,
    output logic                    err_cfg
);

    if ((TN % BEAT_BYTES) != 0) begin : g_bad_cfg
        $fatal(1, "wgt_buffer_loader: TN must be a multiple of BEAT_BYTES");
    end

    localparam logic [ADDR_WIDTH:0] MAX_ROWS = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_ROW  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    ldr_state_e              state_q, state_d;
    logic [ADDR_WIDTH:0]     tile_rows_q, tile_rows_d;
    logic [ADDR_WIDTH-1:0]   row_q, row_d;
    logic                    wr_bank_q, wr_bank_d;
    logic [NUM_BANKS-1:0]    bank_full_q, bank_full_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [TN*8-1:0]         wdata_q, wdata_d;
    logic                    err_len_q, err_len_d;
    logic                    err_cfg_q, err_cfg_d;
    logic                    tile_done_q, tile_done_d;

    logic                    hs;
    logic                    last_beat;
    logic                    row_valid;
    logic [TN*8-1:0]         row_data;
    logic                    final_tile_beat;
    logic                    cfg_legal;

    assign s_ready     = (state_q == FILL);
    assign hs          = s_valid && s_ready;
    assign busy        = (state_q != IDLE);
    assign we          = we_q;
    assign waddr       = waddr_q;
    assign wdata       = wdata_q;
    assign bank_sel_wr = wr_bank_q;
    assign bank_full   = bank_full_q;
    assign tile_done   = tile_done_q;
    assign err_len     = err_len_q;
    assign err_cfg     = err_cfg_q;

    assign cfg_legal       = (tile_rows != '0) && (tile_rows <= MAX_ROWS);
    assign final_tile_beat = last_beat && ({1'b0, row_q} == (tile_rows_q - ONE_ROW));

    wgt_row_packer #(
        .TN         (TN),
        .BEAT_BYTES (BEAT_BYTES)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state_q != FILL),
        .beat_valid (hs),
        .beat_data  (s_data),
        .flush      (s_last),
        .last_beat  (last_beat),
        .row_valid  (row_valid),
        .row_data   (row_data)
    );

    always_comb begin
        state_d     = state_q;
        tile_rows_d = tile_rows_q;
        row_d       = row_q;
        wr_bank_d   = wr_bank_q;
        bank_full_d = bank_full_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        err_len_d   = err_len_q;
        err_cfg_d   = 1'b0;
        tile_done_d = 1'b0;

        // Release is applied first so WAIT_BANK sees it this cycle and a
        // commit on the other bank in the same cycle is not lost.
        if (rel_valid) begin
            bank_full_d[rel_bank] = 1'b0;
        end

        if (row_valid) begin
            we_d    = 1'b1;
            waddr_d = row_q;
            wdata_d = row_data;
            row_d   = row_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_legal) begin
                        tile_rows_d = tile_rows;
                        row_d       = '0;
                        err_len_d   = 1'b0;
                        state_d     = WAIT_BANK;
                    end else begin
                        err_cfg_d = 1'b1;
                    end
                end
            end
            WAIT_BANK: begin
                if (!bank_full_d[wr_bank_q]) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (hs && (s_last || final_tile_beat)) begin
                    state_d = COMMIT;
                    if (s_last != final_tile_beat) begin
                        err_len_d = 1'b1;
                    end
                end
            end
            COMMIT: begin
                bank_full_d[wr_bank_q] = 1'b1;
                wr_bank_d              = ~wr_bank_q;
                tile_done_d            = 1'b1;
                state_d                = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tile_rows_q <= '0;
            row_q       <= '0;
            wr_bank_q   <= 1'b0;
            bank_full_q <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            err_len_q   <= 1'b0;
            err_cfg_q   <= 1'b0;
            tile_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tile_rows_q <= tile_rows_d;
            row_q       <= row_d;
            wr_bank_q   <= wr_bank_d;
            bank_full_q <= bank_full_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            err_len_q   <= err_len_d;
            err_cfg_q   <= err_cfg_d;
            tile_done_q <= tile_done_d;
        end
    end

endmodule

`default_nettype wire
